// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute skid stage: default widths,
// the bubble type code, controller state encoding and the default payload.
package pipe_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_PC_W         = 32;
    localparam int DEF_RD_W         = 5;
    localparam int DEF_TYPE_W       = 3;
    localparam int DEF_INVALID_TYPE = 7;
    localparam int DEF_STAT_W       = 32;

    // EMPTY: nothing held; ONE: main reg valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Decoded instruction fields at the default widths
    typedef struct packed {
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic [DEF_TYPE_W-1:0]   itype;
        logic [DEF_DATA_W-1:0]   rs1;
        logic [DEF_DATA_W-1:0]   rs2;
        logic [DEF_RD_W-1:0]     rd;
        logic [DEF_PC_W-1:0]     PC;
        logic [6:0]              opcode;
    } idex_payload_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Two-entry skid controller: state machine, registered ready/valid decodes
// and load enables for the main (M) and skid (S) payload registers.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        out_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        in_ready,
    output logic        out_valid,
    output logic        m_load,
    output logic        m_sel_skid,
    output logic        s_load,
    output skid_state_t state
);

    skid_state_t state_d;
    logic        rdy_eff;
    logic        in_fire;
    logic        out_fire;

    // Ready and valid come straight from the state register, so no
    // combinational path exists from out_ready to in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign rdy_eff   = out_ready & ~stall;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & rdy_eff;

    // Next state and load enables; flush overrides every transfer
    always_comb begin
        state_d    = state;
        m_load     = 1'b0;
        m_sel_skid = 1'b0;
        s_load     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    m_load  = 1'b1;
                    state_d = ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire) begin
                        s_load  = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    m_load     = 1'b1;
                    m_sel_skid = 1'b1;
                    state_d    = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_d;
    end

endmodule

// File: rtl/idex_skid_stage.sv
// Decode-to-execute pipeline stage with a valid/ready handshake and a
// two-entry skid buffer. An empty stage presents a bubble (type code
// INVALID_TYPE, every other field zero).
// Optional statistics counters: define IDEX_SKID_STAGE_STATS_EN.
module idex_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PC_W         = DEF_PC_W,
    parameter int RD_W         = DEF_RD_W,
    parameter int TYPE_W       = DEF_TYPE_W,
    parameter int INVALID_TYPE = DEF_INVALID_TYPE
`ifdef IDEX_SKID_STAGE_STATS_EN
    ,
    parameter int STAT_W       = DEF_STAT_W
`endif
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic [TYPE_W-1:0] itype,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [RD_W-1:0]   rd,
    input  logic [PC_W-1:0]   PC,
    input  logic [6:0]        opcode,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        funct7_out,
    output logic [2:0]        funct3_out,
    output logic [TYPE_W-1:0] type_out,
    output logic [DATA_W-1:0] rs1_out,
    output logic [DATA_W-1:0] rs2_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [PC_W-1:0]   PC_out,
    output logic [6:0]        opcode_out
`ifdef IDEX_SKID_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_stall,
    output logic [STAT_W-1:0] stat_bubble,
    output logic [STAT_W-1:0] stat_flush
`endif
);

    typedef struct packed {
        logic [6:0]        funct7;
        logic [2:0]        funct3;
        logic [TYPE_W-1:0] itype;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [RD_W-1:0]   rd;
        logic [PC_W-1:0]   PC;
        logic [6:0]        opcode;
    } payload_t;

    localparam payload_t BUBBLE = '{funct7: 7'd0, funct3: 3'd0,
                                    itype: TYPE_W'(INVALID_TYPE),
                                    rs1: '0, rs2: '0, rd: '0, PC: '0,
                                    opcode: 7'd0};

    logic        m_load;
    logic        m_sel_skid;
    logic        s_load;
    skid_state_t state;
    payload_t    in_p;
    payload_t    m_q;
    payload_t    s_q;
    payload_t    head;

    pipe_skid_ctrl u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .stall      (stall),
        .flush      (flush),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .m_load     (m_load),
        .m_sel_skid (m_sel_skid),
        .s_load     (s_load),
        .state      (state)
    );

    assign in_p = '{funct7: funct7, funct3: funct3, itype: itype,
                    rs1: rs1, rs2: rs2, rd: rd, PC: PC, opcode: opcode};

    // Payload registers: M refills from input or skid, S captures overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q <= BUBBLE;
            s_q <= BUBBLE;
        end else if (flush) begin
            m_q <= BUBBLE;
            s_q <= BUBBLE;
        end else begin
            if (m_load) m_q <= m_sel_skid ? s_q : in_p;
            if (s_load) s_q <= in_p;
        end
    end

    // M keeps stale data after draining, so force the bubble while empty
    assign head       = (state == EMPTY) ? BUBBLE : m_q;
    assign funct7_out = head.funct7;
    assign funct3_out = head.funct3;
    assign type_out   = head.itype;
    assign rs1_out    = head.rs1;
    assign rs2_out    = head.rs2;
    assign rd_out     = head.rd;
    assign PC_out     = head.PC;
    assign opcode_out = head.opcode;

`ifdef IDEX_SKID_STAGE_STATS_EN
    logic rdy_eff;
    assign rdy_eff = out_ready & ~stall;

    // Saturating event counters: held head, empty stage, flush cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_stall  <= '0;
            stat_bubble <= '0;
            stat_flush  <= '0;
        end else begin
            if (out_valid && !rdy_eff && (stat_stall != '1))
                stat_stall <= stat_stall + 1'b1;
            if ((state == EMPTY) && (stat_bubble != '1))
                stat_bubble <= stat_bubble + 1'b1;
            if (flush && (stat_flush != '1))
                stat_flush <= stat_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// Self-checking bench for idex_skid_stage: directed scenarios plus a
// randomized run against a queue model of a two-entry FIFO.
module tb_idex_skid_stage;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [2:0]  itype;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] PC;
    logic [6:0]  opcode;
    logic        flush;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  funct7_out;
    logic [2:0]  funct3_out;
    logic [2:0]  type_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [4:0]  rd_out;
    logic [31:0] PC_out;
    logic [6:0]  opcode_out;
`ifdef IDEX_SKID_STAGE_STATS_EN
    logic [31:0] stat_stall;
    logic [31:0] stat_bubble;
    logic [31:0] stat_flush;
`endif

    idex_skid_stage dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct7     (funct7),
        .funct3     (funct3),
        .itype      (itype),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .PC         (PC),
        .opcode     (opcode),
        .flush      (flush),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .funct7_out (funct7_out),
        .funct3_out (funct3_out),
        .type_out   (type_out),
        .rs1_out    (rs1_out),
        .rs2_out    (rs2_out),
        .rd_out     (rd_out),
        .PC_out     (PC_out),
        .opcode_out (opcode_out)
`ifdef IDEX_SKID_STAGE_STATS_EN
        ,
        .stat_stall  (stat_stall),
        .stat_bubble (stat_bubble),
        .stat_flush  (stat_flush)
`endif
    );

    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    idex_payload_t mq[$];
    idex_payload_t bub;
    int            m_stall = 0;
    int            m_bubble = 0;
    int            m_flush = 0;

    function automatic idex_payload_t rnd_p();
        idex_payload_t p;
        p.funct7 = 7'($urandom);
        p.funct3 = 3'($urandom);
        p.itype  = 3'($urandom_range(0, 6));
        p.rs1    = $urandom;
        p.rs2    = $urandom;
        p.rd     = 5'($urandom);
        p.PC     = $urandom;
        p.opcode = 7'($urandom);
        return p;
    endfunction

    function automatic idex_payload_t mk_p(input logic [31:0] pc, input logic [2:0] t, input logic [4:0] r);
        idex_payload_t p;
        p = rnd_p();
        p.PC = pc;
        p.itype = t;
        p.rd = r;
        return p;
    endfunction

    function automatic idex_payload_t obs();
        idex_payload_t p;
        p.funct7 = funct7_out;
        p.funct3 = funct3_out;
        p.itype  = type_out;
        p.rs1    = rs1_out;
        p.rs2    = rs2_out;
        p.rd     = rd_out;
        p.PC     = PC_out;
        p.opcode = opcode_out;
        return p;
    endfunction

    function automatic idex_payload_t exp_head();
        return (mq.size() > 0) ? mq[0] : bub;
    endfunction

    // One clock: drive at negedge, advance the FIFO model at posedge, settle
    task automatic drive_cycle(input logic v, input idex_payload_t p, input logic ordy,
                               input logic stl, input logic fl);
        bit acc;
        bit take;
        @(negedge clock);
        in_valid = v; out_ready = ordy; stall = stl; flush = fl;
        funct7 = p.funct7; funct3 = p.funct3; itype = p.itype; rs1 = p.rs1;
        rs2 = p.rs2; rd = p.rd; PC = p.PC; opcode = p.opcode;
        @(posedge clock);
        acc  = v && (mq.size() < 2);
        take = (mq.size() > 0) && ordy && !stl;
        if (mq.size() > 0 && !(ordy && !stl)) m_stall++;
        if (mq.size() == 0) m_bubble++;
        if (fl) m_flush++;
        if (fl) mq.delete();
        else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(p);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        funct7 = 7'h11; funct3 = 3'h2; itype = 3'h1; rs1 = 32'hdead; rs2 = 32'hbeef;
        rd = 5'h3; PC = 32'h40; opcode = 7'h33;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_transfer out_valid=%b exp 0", out_valid); end
        in_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1; #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (type_out !== 3'd7) begin fails++; $display("FAIL reset_type_out got %0d exp 7", type_out); end
        tests++; if (rs1_out !== 32'd0 || PC_out !== 32'd0) begin fails++; $display("FAIL reset_data rs1=%h PC=%h exp 0", rs1_out, PC_out); end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, mk_p(32'h100, 3'd2, 5'd5), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || PC_out !== 32'h100) begin fails++; $display("FAIL single_head vld=%b PC=%h exp 1/100", out_valid, PC_out); end
        tests++; if (type_out !== 3'd2 || rd_out !== 5'd5) begin fails++; $display("FAIL single_fields type=%0d rd=%0d exp 2/5", type_out, rd_out); end
        drive_cycle(1'b0, rnd_p(), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b0 || type_out !== 3'd7) begin fails++; $display("FAIL single_drain vld=%b type=%0d exp 0/7", out_valid, type_out); end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, mk_p(32'h0, 3'd1, 5'd1), 1'b0, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b1 || PC_out !== 32'h0) begin fails++; $display("FAIL bp_first rdy=%b PC=%h exp 1/0", in_ready, PC_out); end
        drive_cycle(1'b1, mk_p(32'h4, 3'd1, 5'd2), 1'b0, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b0 || PC_out !== 32'h0) begin fails++; $display("FAIL bp_full rdy=%b PC=%h exp 0/0", in_ready, PC_out); end
        drive_cycle(1'b1, mk_p(32'h8, 3'd1, 5'd3), 1'b1, 1'b0, 1'b0);
        tests++; if (PC_out !== 32'h4 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_second PC=%h rdy=%b exp 4/1", PC_out, in_ready); end
        drive_cycle(1'b1, mk_p(32'h8, 3'd1, 5'd3), 1'b1, 1'b0, 1'b0);
        tests++; if (PC_out !== 32'h8 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_third PC=%h vld=%b exp 8/1", PC_out, out_valid); end
        drive_cycle(1'b0, rnd_p(), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty vld=%b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, rnd_p(), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, rnd_p(), 1'b0, 1'b0, 1'b0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefill rdy=%b exp 0", in_ready); end
        drive_cycle(1'b1, mk_p(32'h777, 3'd3, 5'd9), 1'b0, 1'b0, 1'b1);
        tests++; if (out_valid !== 1'b0 || type_out !== 3'd7 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_empty vld=%b type=%0d rdy=%b exp 0/7/1", out_valid, type_out, in_ready); end
        drive_cycle(1'b0, rnd_p(), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b0 || PC_out !== 32'h0) begin fails++; $display("FAIL flush_dropped vld=%b PC=%h exp 0/0", out_valid, PC_out); end
    endtask

    task automatic test_stall();
        drive_cycle(1'b1, mk_p(32'h200, 3'd4, 5'd7), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, rnd_p(), 1'b1, 1'b1, 1'b0);
            tests++; if (out_valid !== 1'b1 || PC_out !== 32'h200) begin
                fails++; $display("FAIL stall_hold[%0d] vld=%b PC=%h exp 1/200", i, out_valid, PC_out); end
        end
`ifdef IDEX_SKID_STAGE_STATS_EN
        tests++; if (stat_stall !== 32'(m_stall)) begin fails++; $display("FAIL stat_stall got %0d exp %0d", stat_stall, m_stall); end
        tests++; if (stat_bubble !== 32'(m_bubble)) begin fails++; $display("FAIL stat_bubble got %0d exp %0d", stat_bubble, m_bubble); end
        tests++; if (stat_flush !== 32'(m_flush)) begin fails++; $display("FAIL stat_flush got %0d exp %0d", stat_flush, m_flush); end
`endif
        drive_cycle(1'b0, rnd_p(), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_release vld=%b exp 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), rnd_p(), 1'($urandom_range(0, 2) != 0),
                        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            tests++; if (out_valid !== (mq.size() > 0)) begin
                fails++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, mq.size() > 0); end
            tests++; if (in_ready !== (mq.size() < 2)) begin
                fails++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, mq.size() < 2); end
            tests++; if (obs() !== exp_head()) begin
                fails++; $display("FAIL rnd_head[%0d] got %h exp %h", i, obs(), exp_head()); end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, rnd_p(), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, rnd_p(), 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || type_out !== 3'd7 || PC_out !== 32'd0) begin
            fails++; $display("FAIL async_reset vld=%b rdy=%b type=%0d PC=%h exp 0/1/7/0", out_valid, in_ready, type_out, PC_out); end
        mq.delete();
        in_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        drive_cycle(1'b1, mk_p(32'h300, 3'd5, 5'd1), 1'b1, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || PC_out !== 32'h300) begin
            fails++; $display("FAIL async_recover vld=%b PC=%h exp 1/300", out_valid, PC_out); end
    endtask

    initial begin
        bub = '0;
        bub.itype = 3'd7;
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_stall();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idex_skid_stage.md
Name: idex_skid_stage

Overview:
Parametrised successor to the ID/EX pipeline register. It carries the decoded instruction fields from the decode stage to the execute stage. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not need a combinational ready path. Synchronous flush and legacy stall are supported, and an empty stage presents an explicit bubble.

Parameters:
DATA_W, 32, width of rs1/rs2 operand values
PC_W, 32, width of PC
RD_W, 5, destination register index width
TYPE_W, 3, instruction type code width
INVALID_TYPE, 7, type code presented when the stage is empty (bubble)
STAT_W, 32, width of statistics counters (optional feature only)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream offers an instruction
in_ready  out  1  stage can accept; decoded from state register only
funct7  in  7  decoded funct7
funct3  in  3  decoded funct3
type  in  TYPE_W  instruction type code
rs1  in  DATA_W  operand 1 value
rs2  in  DATA_W  operand 2 value
rd  in  RD_W  destination index
PC  in  PC_W  instruction PC
opcode  in  7  opcode
flush  in  1  synchronous kill of all held entries
stall  in  1  legacy hold; masks out_ready
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
funct7_out, funct3_out, type_out, rs1_out, rs2_out, rd_out, PC_out, opcode_out  out  matching widths  head entry fields

Behaviour:
- Definitions: rdy_eff = out_ready & ~stall; in_fire = in_valid & in_ready; out_fire = out_valid & rdy_eff.
- Storage: main reg M drives the outputs; skid reg S holds overflow.
- State: EMPTY, ONE (M valid), FULL (M and S valid).
- Decodes: in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: in_fire -> M<=in, go to ONE.
- ONE, in_fire & out_fire -> M<=in, stay in ONE.
- ONE, in_fire & ~out_fire -> S<=in, go to FULL.
- ONE, ~in_fire & out_fire -> go to EMPTY.
- FULL: out_fire -> M<=S, go to ONE. in_fire is impossible here (in_ready=0).
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput is 1 instruction/cycle with out_ready held high.
- Bubble: while EMPTY, type_out=INVALID_TYPE and all other outputs are 0. Execute ignores INVALID_TYPE.
- Flush: highest priority, synchronous. Next state is EMPTY and M/S are cleared to bubble values. A coincident in_fire is dropped and a coincident out_fire is still counted as taken downstream.
- Stall=1: outputs hold. Input is still accepted while not FULL.
- Reset (async, low): state EMPTY, M/S cleared, type_out=INVALID_TYPE, other outputs 0, out_valid=0, in_ready=1. Mid-operation reset discards both entries immediately.
- Release of reset: no transfer in the first clock edge while reset is low. No X on any output after reset.
- M/S data registers load only on the transitions listed above. No other data movement.

Optional Feature:
- Macro: IDEX_SKID_STAGE_STATS_EN.
- Defined: adds outputs stat_stall, stat_bubble, stat_flush (STAT_W each), cleared by reset.
  - stat_stall increments when out_valid & ~rdy_eff.
  - stat_bubble increments when state==EMPTY.
  - stat_flush increments on each flush cycle.
  - All counters saturate at all-ones.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - INVALID_TYPE default
  - state enum {EMPTY, ONE, FULL}
  - packed struct idex_payload_t (funct7, funct3, type, rs1, rs2, rd, PC, opcode), widths from package constants.
- One natural sub-module: pipe_skid_ctrl. It contains the 3-state FSM plus in_ready/out_valid and M/S load enables. The top level holds the payload registers and the optional counters.

Test Plan:
- Reset low then high, no input -> out_valid=0, in_ready=1, type_out=7, rs1_out=0.
- One instr (PC=0x100, type=2, rd=5), out_ready=1 -> out_valid=1 with PC_out=0x100 next cycle; EMPTY the cycle after.
- Stream PCs 0x0,0x4,0x8 with out_ready=0 for 2 cycles:
  - in_ready drops after the 2nd accept.
  - When out_ready rises, outputs present 0x0, 0x4, then accepted 0x8, in order with no loss.
- FULL plus flush=1 with in_valid=1 -> next cycle EMPTY, type_out=7, in_ready=1, flushed input not emitted.
- stall=1 with out_ready=1 and an entry held -> PC_out stable. With the STATS macro defined, stat_stall equals the stall cycle count.
- Assert reset while FULL -> outputs clear immediately, without waiting for a clock edge.
